// File: rtl/alu_pkg.sv
// Shared opcodes, funct codes, FSM encoding and decode helper
// for the integer ALU issue / write-back block.
package alu_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;

    // Shift immediates with instr[25] set (shamt >= 32) are rejected.
    function automatic logic instr_legal(input logic [31:0] instr);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        instr_legal = 1'b0;
        if (instr[6:0] == OPC_OP) begin
            instr_legal = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) &&
                           ((f3 == F3_ADD) || (f3 == F3_SR)));
        end else if (instr[6:0] == OPC_OP_IMM) begin
            if (f3 == F3_SLL)
                instr_legal = (f7 == F7_BASE);
            else if (f3 == F3_SR)
                instr_legal = !instr[31] && (instr[29:25] == 5'd0);
            else
                instr_legal = 1'b1;
        end
    endfunction

endpackage

// File: rtl/regfile_32x64.sv
// Integer register file: one synchronous write port, two
// combinational read ports, a debug read port, x0 reads zero.
module regfile_32x64
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    output logic [XLEN-1:0] o_rdata1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata2,
    input  logic [4:0]      i_dbg_addr,
    output logic [XLEN-1:0] o_dbg_data
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_mem[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = (i_raddr1 == 5'd0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2   = (i_raddr2 == 5'd0) ? '0 : r_mem[i_raddr2];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Three-state issue / write-back sequencer feeding an external ALU
// and retiring its result into the integer register file.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_instr_valid,
    input  logic [31:0]     in_instr,
    output logic            out_instr_ready,
    output logic [XLEN-1:0] out_alu_rs1,
    output logic [XLEN-1:0] out_alu_rs2,
    output logic [2:0]      out_alu_funct3,
    output logic            out_alu_funct7,
    input  logic [XLEN-1:0] in_alu_rd,
    output logic            out_wb_valid,
    output logic [4:0]      out_wb_addr,
    output logic [XLEN-1:0] out_wb_data,
    output logic            out_illegal,
    input  logic [4:0]      in_dbg_addr,
    output logic [XLEN-1:0] out_dbg_data
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_res;
    logic [2:0]      r_f3;
    logic            r_f7;
    logic [4:0]      r_rd;
    logic            r_illegal;

    logic            w_accept;
    logic            w_legal;
    logic            w_is_op;
    logic            w_f7;
    logic            w_we;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;

    assign out_instr_ready = (r_state == S_IDLE);
    assign w_accept = in_instr_valid && out_instr_ready;
    assign w_legal  = instr_legal(in_instr);
    assign w_is_op  = (in_instr[6:0] == OPC_OP);
    assign w_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    // Only SRAI carries the alternate bit among immediates.
    assign w_f7 = w_is_op ? in_instr[30]
                          : ((in_instr[14:12] == F3_SR) && in_instr[30]);

    assign w_we = (r_state == S_ISSUE) && (r_rd != 5'd0);

    regfile_32x64 #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (in_alu_rd),
        .i_raddr1   (in_instr[19:15]),
        .o_rdata1   (w_rs1_val),
        .i_raddr2   (in_instr[24:20]),
        .o_rdata2   (w_rs2_val),
        .i_dbg_addr (in_dbg_addr),
        .o_dbg_data (out_dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_res     <= '0;
            r_f3      <= '0;
            r_f7      <= 1'b0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_legal) begin
                        r_rs1   <= w_rs1_val;
                        r_rs2   <= w_is_op ? w_rs2_val : w_imm;
                        r_f3    <= in_instr[14:12];
                        r_f7    <= w_f7;
                        r_rd    <= in_instr[11:7];
                        r_state <= S_ISSUE;
                    end else if (w_accept) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_res   <= in_alu_rd;
                    r_state <= S_WB;
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_alu_rs1    = r_rs1;
    assign out_alu_rs2    = r_rs2;
    assign out_alu_funct3 = r_f3;
    assign out_alu_funct7 = r_f7;
    assign out_illegal    = r_illegal;

    assign out_wb_valid = (r_state == S_WB) && (r_rd != 5'd0);
    assign out_wb_addr  = out_wb_valid ? r_rd : 5'd0;
    assign out_wb_data  = out_wb_valid ? r_res : '0;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed vector bench for alu_issue_wb with a behavioural
// model of the external ALU.
module tb_alu_issue_wb;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            in_instr_valid;
    logic [31:0]     in_instr;
    logic            out_instr_ready;
    logic [XLEN-1:0] out_alu_rs1;
    logic [XLEN-1:0] out_alu_rs2;
    logic [2:0]      out_alu_funct3;
    logic            out_alu_funct7;
    logic [XLEN-1:0] in_alu_rd;
    logic            out_wb_valid;
    logic [4:0]      out_wb_addr;
    logic [XLEN-1:0] out_wb_data;
    logic            out_illegal;
    logic [4:0]      in_dbg_addr;
    logic [XLEN-1:0] out_dbg_data;

    int n_chk  = 0;
    int n_pass = 0;

    alu_issue_wb #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_instr_valid  (in_instr_valid),
        .in_instr        (in_instr),
        .out_instr_ready (out_instr_ready),
        .out_alu_rs1     (out_alu_rs1),
        .out_alu_rs2     (out_alu_rs2),
        .out_alu_funct3  (out_alu_funct3),
        .out_alu_funct7  (out_alu_funct7),
        .in_alu_rd       (in_alu_rd),
        .out_wb_valid    (out_wb_valid),
        .out_wb_addr     (out_wb_addr),
        .out_wb_data     (out_wb_data),
        .out_illegal     (out_illegal),
        .in_dbg_addr     (in_dbg_addr),
        .out_dbg_data    (out_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: RV semantics, 5-bit shift amount.
    always_comb begin
        logic [4:0] sh;
        sh = out_alu_rs2[4:0];
        in_alu_rd = '0;
        case (out_alu_funct3)
            3'd0: in_alu_rd = out_alu_funct7 ? out_alu_rs1 - out_alu_rs2
                                             : out_alu_rs1 + out_alu_rs2;
            3'd1: in_alu_rd = out_alu_rs1 << sh;
            3'd2: in_alu_rd = {63'd0, $signed(out_alu_rs1) < $signed(out_alu_rs2)};
            3'd3: in_alu_rd = {63'd0, out_alu_rs1 < out_alu_rs2};
            3'd4: in_alu_rd = out_alu_rs1 ^ out_alu_rs2;
            3'd5: in_alu_rd = out_alu_funct7 ? $unsigned($signed(out_alu_rs1) >>> sh)
                                             : out_alu_rs1 >> sh;
            3'd6: in_alu_rd = out_alu_rs1 | out_alu_rs2;
            default: in_alu_rd = out_alu_rs1 & out_alu_rs2;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic dbg_chk(input string nm, input logic [4:0] a,
                           input logic [63:0] exp);
        in_dbg_addr = a;
        #1;
        chk(nm, out_dbg_data, exp);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] rs2;
        logic [2:0]  f3;
        logic        f7;
    } vec_t;

    vec_t vecs [10];

    // Enter at a negedge in IDLE; leave at a negedge back in IDLE.
    task automatic run_vec(input vec_t v);
        int t;
        t = 0;
        while (!out_instr_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t == 10) chk("ready_timeout", 64'd0, 64'd1);
        in_instr = v.instr;
        in_instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_instr_valid = 1'b0;
        in_instr = 32'hFFFF_FFFF;
        if (v.legal) begin
            chk("issue_ready", {63'd0, out_instr_ready}, 64'd0);
            chk("funct3", {61'd0, out_alu_funct3}, {61'd0, v.f3});
            chk("funct7", {63'd0, out_alu_funct7}, {63'd0, v.f7});
            chk("rs2", out_alu_rs2, v.rs2);
            @(negedge clk);
            chk("wb_valid", {63'd0, out_wb_valid}, {63'd0, v.rd != 5'd0});
            chk("wb_addr", {59'd0, out_wb_addr},
                (v.rd != 5'd0) ? {59'd0, v.rd} : 64'd0);
            chk("wb_data", out_wb_data, (v.rd != 5'd0) ? v.data : 64'd0);
            dbg_chk("dbg_rd", v.rd, (v.rd != 5'd0) ? v.data : 64'd0);
            @(negedge clk);
            chk("ready_back", {63'd0, out_instr_ready}, 64'd1);
        end else begin
            chk("illegal_pulse", {63'd0, out_illegal}, 64'd1);
            chk("illegal_ready", {63'd0, out_instr_ready}, 64'd1);
            chk("illegal_nowb", {63'd0, out_wb_valid}, 64'd0);
            @(negedge clk);
            chk("illegal_clear", {63'd0, out_illegal}, 64'd0);
            chk("illegal_nowb2", {63'd0, out_wb_valid}, 64'd0);
        end
    endtask

    initial begin
        int acc;
        logic [8:0] rdy_pat;

        vecs[0] = '{32'hFFB00093, 1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFB,
                    64'hFFFF_FFFF_FFFF_FFFB, 3'd0, 1'b0};
        vecs[1] = '{32'h00700113, 1'b1, 5'd2, 64'd7, 64'd7, 3'd0, 1'b0};
        vecs[2] = '{32'h402081B3, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFF4,
                    64'd7, 3'd0, 1'b1};
        vecs[3] = '{32'h4010D213, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD,
                    64'h401, 3'd5, 1'b1};
        vecs[4] = '{32'h02109213, 1'b0, 5'd4, 64'd0, 64'd0, 3'd1, 1'b0};
        vecs[5] = '{32'h4020C2B3, 1'b0, 5'd5, 64'd0, 64'd0, 3'd4, 1'b1};
        vecs[6] = '{32'h0000B083, 1'b0, 5'd1, 64'd0, 64'd0, 3'd3, 1'b0};
        vecs[7] = '{32'h00900013, 1'b1, 5'd0, 64'd0, 64'd9, 3'd0, 1'b0};
        vecs[8] = '{32'h0020C2B3, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFC,
                    64'd7, 3'd4, 1'b0};
        vecs[9] = '{32'h0040D313, 1'b1, 5'd6, 64'h0FFF_FFFF_FFFF_FFFF,
                    64'd4, 3'd5, 1'b0};

        rst_n = 1'b0;
        in_instr_valid = 1'b0;
        in_instr = 32'd0;
        in_dbg_addr = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, out_instr_ready}, 64'd1);
        chk("rst_rs1", out_alu_rs1, 64'd0);
        chk("rst_wb_valid", {63'd0, out_wb_valid}, 64'd0);
        chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            if (i == 4)
                dbg_chk("x4_kept", 5'd4, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        dbg_chk("x0_zero", 5'd0, 64'd0);
        dbg_chk("x3_final", 5'd3, 64'hFFFF_FFFF_FFFF_FFF4);

        // Back-to-back ADDI x7,x7,1 with valid held high.
        acc = 0;
        rdy_pat = '0;
        in_instr = 32'h00138393;
        in_instr_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            rdy_pat[8-k] = out_instr_ready;
            if (out_instr_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        in_instr_valid = 1'b0;
        chk("b2b_accepts", acc, 64'd3);
        chk("b2b_ready_pat", {55'd0, rdy_pat}, {55'd0, 9'b100100100});
        dbg_chk("b2b_x7", 5'd7, 64'd3);

        // Reset in the middle of ISSUE for ADDI x5,x0,1.
        in_instr = 32'h00100293;
        in_instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_instr_valid = 1'b0;
        chk("pre_rst_issue", {63'd0, out_instr_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_rs2", out_alu_rs2, 64'd0);
        chk("abort_wb", {63'd0, out_wb_valid}, 64'd0);
        chk("abort_f3f7", {60'd0, out_alu_funct3, out_alu_funct7}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {63'd0, out_instr_ready}, 64'd1);
        chk("abort_nowb", {63'd0, out_wb_valid}, 64'd0);
        dbg_chk("abort_x5", 5'd5, 64'd0);
        dbg_chk("abort_x1", 5'd1, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
